jtag_host_seq: RTL
==================

# jtag_host_seq

JTAG host-side sequencer that drives a 1149.1 TAP controller from the initiator end. It accepts reset, idle, IR-scan and DR-scan commands over a valid/ready interface and generates TCK, TMS and TDI. It samples TDO and returns the captured shift data over a response handshake. It keeps its own mirror of the target TAP state so every scan starts and ends in Run-Test/Idle.

## Interface
- DW, 32: maximum scan length and width of the data paths, in bits.
- LEN_W, 6: width of cmd_len. Must satisfy 2^LEN_W > DW.
- clk  in  1  system clock. TCK is derived from clk.
- TRST  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
- cmd_op  in  2  command type: 0 RESET, 1 IDLE, 2 IR_SCAN, 3 DR_SCAN.
- cmd_len  in  LEN_W  shift length for scans, or number of TCK cycles for IDLE.
- cmd_data  in  DW  TDI data, shifted out LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  DW  captured TDO data, right-aligned, LSB first.
- tck_o  out  1  TCK to the target.
- tms_o  out  1  TMS to the target.
- tdi_o  out  1  TDI to the target.
- tdo_i  in  1  TDO from the target.
- state_obs  out  4  mirrored TAP state. Present only when JTAG_HOST_STATE_OBS_EN is defined.

## Operation
- **Reset values:** tck_o=0, tms_o=1, tdi_o=0, cmd_ready=1, rsp_valid=0, rsp_data=0, mirror=Test_logic_Reset.
- **TCK generation:**
  - While busy, tck_o toggles on every clk edge, so one TCK period is 2 clk.
  - tms_o and tdi_o update on the clk edge that drives tck_o low.
  - tdo_i is sampled on the clk edge that drives tck_o high.
  - While idle, tck_o is held at 0.
- **Command acceptance:** cmd_ready is high only in the IDLE controller state with no pending response.
- **Mirror:** the mirror advances on every TCK rising edge using the standard 16-state TMS transition function.
- **Controller states:** IDLE, PREFIX, WALK_IN, SHIFT, WALK_OUT, RESP.
- **RESET command:** 5 TCK with TMS=1, then 1 TCK with TMS=0. Ends in Run-Test/Idle. rsp_data=0.
- **IDLE command:** cmd_len TCK with TMS=0. cmd_len=0 goes directly to RESP with no TCK.
- **IR_SCAN walk-in:** TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- **DR_SCAN walk-in:** TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- **SHIFT:**
  - Runs N TCK. tdi_o = cmd_data[i] during bit i.
  - TMS=0, except TMS=1 on bit N-1, which moves the TAP to Exit1.
  - The TDO sample on rising edge i is stored in rsp_data[i]. Bits N..DW-1 are 0.
- **WALK_OUT:** TMS 1,0 (Update, Run-Test/Idle).
- **PREFIX:** if the mirror is Test_logic_Reset when a scan or IDLE command is accepted, one TCK with TMS=0 is inserted first to reach Run-Test/Idle.
- **Length rules:** for scans, cmd_len=0 is treated as 1 and cmd_len>DW is clamped to DW.
- **RESP:** rsp_valid is held until rsp_ready. Returns to IDLE on the same edge as the handshake.
- **TRST mid-operation:** all registers return to reset values immediately. The partial response is discarded.

## Timing
- **Scan TCK count** (no prefix): IR_SCAN takes N+6 TCK; DR_SCAN takes N+5 TCK. A prefix adds 1.
- **Response latency:** rsp_valid rises 1 clk after the last TCK falling edge.
- **IR_SCAN example:** with N=4 from Run-Test/Idle, cmd accepted at edge 0 gives rsp_valid at edge 2·10+1=21.
- **Back-to-back commands:** the next command can be accepted on the clk after the rsp handshake. No bubble is required beyond that.
- **Input stability:** cmd_* inputs are registered at acceptance and may change afterwards.

## Configuration
- **JTAG_HOST_STATE_OBS_EN defined:** the state_obs[3:0] port exists and carries the mirror state, registered, using the package encoding.
- **JTAG_HOST_STATE_OBS_EN undefined:** the port is absent. The mirror still exists internally and behaviour is otherwise identical.

## Structure
- **Shared package tap_pkg** holds:
  - the 4-bit TAP state encoding: Test_logic_Reset=0, Run_Test_Idle=1, Select_DR_Scan=2, Capture_DR=3, Shift_DR=4, Exit1_DR=5, Pause_DR=6, Exit2_DR=7, Update_DR=8, Select_IR_Scan=9, Capture_IR=10, Shift_IR=11, Exit1_IR=12, Pause_IR=13, Exit2_IR=14, Update_IR=15;
  - the cmd_op encodings;
  - a next-state function next_tap(state, tms).
- **Sub-module tap_state_mirror:** clocked on the TCK rising phase. Inputs tms and advance; output state. Reset to Test_logic_Reset on TRST.

## Test plan
- **TRST reset:** assert TRST mid-way through a DR scan -> all outputs return to reset values within the same clk; the next command is accepted; the mirror is 0.
- **RESET command:** issue RESET -> TMS sequence 1,1,1,1,1,0; 6 TCK; mirror ends at 1; rsp_data=0.
- **IR_SCAN with prefix:** right after TRST, IR_SCAN N=4, data 0xA -> TMS 0,1,1,0,0,0,0,0,1,1,0; TDI during shift 0,1,0,1. With a TAP model loopback TDI->TDO, rsp_data=0xA.
- **DR_SCAN full width:** DR_SCAN N=32, data 0xDEADBEEF, looped back -> rsp_data=0xDEADBEEF; 37 TCK; mirror passes through 4 and ends at 1.
- **Length edge cases:** DR_SCAN cmd_len=0 -> exactly 1 shift bit. cmd_len=40 -> 32 shift bits. IDLE cmd_len=0 -> rsp_valid 1 clk after acceptance, no TCK.
- **Response back-pressure:** hold rsp_ready=0 for 10 clk -> rsp_valid and rsp_data stay stable, cmd_ready=0, tck_o=0.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared definitions for the JTAG host sequencer.
// Contents:
//   tap_state_e  - 4-bit IEEE 1149.1 TAP state encoding
//   cmd_op_e     - host command opcodes (RESET, IDLE, IR_SCAN, DR_SCAN)
//   ctrl_state_e - host controller states
//   next_tap()   - standard 16-state TMS transition function
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_TEST_LOGIC_RESET = 4'd0,
    TAP_RUN_TEST_IDLE    = 4'd1,
    TAP_SELECT_DR_SCAN   = 4'd2,
    TAP_CAPTURE_DR       = 4'd3,
    TAP_SHIFT_DR         = 4'd4,
    TAP_EXIT1_DR         = 4'd5,
    TAP_PAUSE_DR         = 4'd6,
    TAP_EXIT2_DR         = 4'd7,
    TAP_UPDATE_DR        = 4'd8,
    TAP_SELECT_IR_SCAN   = 4'd9,
    TAP_CAPTURE_IR       = 4'd10,
    TAP_SHIFT_IR         = 4'd11,
    TAP_EXIT1_IR         = 4'd12,
    TAP_PAUSE_IR         = 4'd13,
    TAP_EXIT2_IR         = 4'd14,
    TAP_UPDATE_IR        = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    CS_IDLE     = 3'd0,
    CS_PREFIX   = 3'd1,
    CS_WALK_IN  = 3'd2,
    CS_SHIFT    = 3'd3,
    CS_WALK_OUT = 3'd4,
    CS_RESP     = 3'd5
  } ctrl_state_e;

  // TAP state after one TCK rising edge with the given TMS.
  function automatic tap_state_e next_tap(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    case (state)
      TAP_TEST_LOGIC_RESET: nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR_SCAN:   nxt = tms ? TAP_SELECT_IR_SCAN   : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         nxt = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR_SCAN:   nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         nxt = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        nxt = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
      default:              nxt = TAP_TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tap_state_mirror.sv
// Host-side copy of the target TAP controller state.
// Ports:
//   clk     in   system clock
//   TRST    in   asynchronous active-high reset (state -> Test_logic_Reset)
//   tms     in   TMS currently presented to the target
//   advance in   high on the clk edge that drives TCK high
//   state   out  mirrored TAP state (registered, tap_pkg encoding)
module tap_state_mirror
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       TRST,
  input  logic       tms,
  input  logic       advance,
  output logic [3:0] state
);

  tap_state_e state_q;

  // Step the mirror once per TCK rising edge.
  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      state_q <= TAP_TEST_LOGIC_RESET;
    end else if (advance) begin
      state_q <= next_tap(state_q, tms);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_host_seq.sv
// JTAG host sequencer: turns RESET / IDLE / IR_SCAN / DR_SCAN commands into
// TCK/TMS/TDI waveforms, captures TDO and returns it over a response handshake.
// Every scan starts and ends in Run-Test/Idle; a host-side TAP mirror decides
// whether a leading TMS=0 TCK is needed to leave Test_logic_Reset.
// Optional feature macro: JTAG_HOST_STATE_OBS_EN adds the state_obs port.
// Ports:
//   clk, TRST                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_op/cmd_len/cmd_data payload
//   rsp_valid/rsp_ready       response handshake; rsp_data captured TDO (LSB first)
//   tck_o, tms_o, tdi_o       JTAG outputs to the target
//   tdo_i                     JTAG TDO from the target
//   state_obs                 mirrored TAP state (only with JTAG_HOST_STATE_OBS_EN)
module jtag_host_seq
  import tap_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             TRST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DW-1:0]    cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             tck_o,
  output logic             tms_o,
  output logic             tdi_o,
  input  logic             tdo_i
`ifdef JTAG_HOST_STATE_OBS_EN
  ,
  output logic [3:0]       state_obs
`endif
);

  localparam int IDX_W = $clog2(DW);
  localparam logic [LEN_W-1:0] DW_L = LEN_W'(DW);

  // TMS walk pattern, consumed LSB first.
  function automatic logic [5:0] walk_pat(input cmd_op_e op);
    case (op)
      OP_RESET:   return 6'b011111;
      OP_IR_SCAN: return 6'b000011;
      OP_DR_SCAN: return 6'b000001;
      default:    return 6'b000000;
    endcase
  endfunction

  // Walk length minus one (counter counts the bits still to follow).
  function automatic logic [LEN_W-1:0] walk_cnt(input cmd_op_e op, input logic [LEN_W-1:0] len);
    case (op)
      OP_RESET:   return LEN_W'(3'd5);
      OP_IR_SCAN: return LEN_W'(3'd3);
      OP_DR_SCAN: return LEN_W'(3'd2);
      default:    return len - LEN_W'(1'b1);
    endcase
  endfunction

  // Index of the last shift bit: length 0 behaves as 1, lengths above DW clamp.
  function automatic logic [IDX_W-1:0] shift_last(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] eff;
    if (len == '0) begin
      eff = LEN_W'(1'b1);
    end else if (len > DW_L) begin
      eff = DW_L;
    end else begin
      eff = len;
    end
    return IDX_W'(eff - LEN_W'(1'b1));
  endfunction

  ctrl_state_e      state_q, state_d;
  cmd_op_e          op_q, op_d;
  logic [DW-1:0]    data_q, data_d;
  logic [DW-1:0]    cap_q, cap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] nlast_q, nlast_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [5:0]       wk_q, wk_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0] idx_nx_s;
  logic             busy_s;
  logic             advance_s;
  logic [3:0]       mirror_raw_s;
  tap_state_e       mirror_s;

  assign idx_nx_s  = idx_q + IDX_W'(1'b1);
  assign busy_s    = (state_q == CS_PREFIX) || (state_q == CS_WALK_IN) ||
                     (state_q == CS_SHIFT)  || (state_q == CS_WALK_OUT);
  // The mirror steps on the edge that drives TCK high, using the TMS set up a clk earlier.
  assign advance_s = busy_s && !tck_q;
  assign mirror_s  = tap_state_e'(mirror_raw_s);

  tap_state_mirror u_mirror (
    .clk     (clk),
    .TRST    (TRST),
    .tms     (tms_q),
    .advance (advance_s),
    .state   (mirror_raw_s)
  );

  // Next-state logic. In busy states odd edges raise TCK (TDO sampled),
  // even edges lower TCK and present the next TMS/TDI bit.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    nlast_d     = nlast_q;
    cnt_d       = cnt_q;
    wk_d        = wk_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      CS_IDLE: begin
        tck_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op_e'(cmd_op);
          data_d  = cmd_data;
          cap_d   = '0;
          idx_d   = '0;
          nlast_d = shift_last(cmd_len);
          wk_d    = walk_pat(op_d);
          cnt_d   = walk_cnt(op_d, cmd_len);
          // A zero-length IDLE produces no TCK at all, so no prefix either.
          if (op_d == OP_IDLE && cmd_len == '0) begin
            state_d = CS_RESP;
          end else if (op_d != OP_RESET && mirror_s == TAP_TEST_LOGIC_RESET) begin
            state_d = CS_PREFIX;
            tms_d   = 1'b0;
          end else begin
            state_d = CS_WALK_IN;
            tms_d   = wk_d[0];
          end
        end else begin
          state_d = CS_IDLE;
        end
      end

      CS_PREFIX: begin
        tck_d = ~tck_q;
        if (tck_q) begin
          state_d = CS_WALK_IN;
          tms_d   = wk_q[0];
        end else begin
          state_d = CS_PREFIX;
        end
      end

      CS_WALK_IN, CS_WALK_OUT: begin
        tck_d = ~tck_q;
        if (!tck_q) begin
          state_d = state_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1'b1);
          wk_d  = {1'b0, wk_q[5:1]};
          tms_d = wk_q[1];
        end else if (state_q == CS_WALK_IN && op_q[1]) begin
          // Scans (IR/DR have op bit 1 set) continue into the shift phase.
          state_d = CS_SHIFT;
          tms_d   = (nlast_q == '0);
          tdi_d   = data_q[0];
        end else begin
          state_d = CS_RESP;
        end
      end

      CS_SHIFT: begin
        tck_d = ~tck_q;
        if (!tck_q) begin
          cap_d[idx_q] = tdo_i;
        end else if (idx_q != nlast_q) begin
          idx_d = idx_nx_s;
          tdi_d = data_q[idx_nx_s];
          tms_d = (idx_nx_s == nlast_q);
        end else begin
          // Exit1 reached; walk out with TMS 1,0 to Run-Test/Idle.
          state_d = CS_WALK_OUT;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          cnt_d   = LEN_W'(1'b1);
          wk_d    = 6'b000001;
        end
      end

      CS_RESP: begin
        tck_d = 1'b0;
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = CS_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = CS_IDLE;
        tck_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == CS_IDLE);
  end

  // Controller and output registers.
  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      state_q     <= CS_IDLE;
      op_q        <= OP_RESET;
      data_q      <= '0;
      cap_q       <= '0;
      idx_q       <= '0;
      nlast_q     <= '0;
      cnt_q       <= '0;
      wk_q        <= 6'b000000;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      nlast_q     <= nlast_d;
      cnt_q       <= cnt_d;
      wk_q        <= wk_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tck_o     = tck_q;
  assign tms_o     = tms_q;
  assign tdi_o     = tdi_q;
`ifdef JTAG_HOST_STATE_OBS_EN
  assign state_obs = mirror_raw_s;
`endif

endmodule
